// File: rtl/sha256_nonce_scheduler.sv
// sha256_nonce_scheduler
// Sweeps nonces 0..NUM_NONCES-1 across NUM_CORES double-SHA256 cores.
// Each nonce goes to the lowest-index free core. The core's H0 result is
// captured when it finishes. Captured results are written to memory one
// word per cycle in round-robin order, at output_addr + nonce.
module sha256_nonce_scheduler #(
  parameter int NUM_CORES  = 4,
  parameter int NUM_NONCES = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [15:0]             output_addr,
  output logic                    done,
  output logic [NUM_CORES-1:0]    core_start,
  output logic [31:0]             core_nonce,
  input  logic [NUM_CORES-1:0]    core_done,
  input  logic [32*NUM_CORES-1:0] core_hash,
  output logic                    mem_we,
  output logic [15:0]             mem_addr,
  output logic [31:0]             mem_write_data
);

  localparam int NW = $clog2(NUM_NONCES + 1);
  localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t               state_r, state_s;
  logic [NUM_CORES-1:0] busy_r, busy_s;
  logic [NUM_CORES-1:0] pending_r, pending_s;
  logic [NW-1:0]        next_nonce_r, next_nonce_s;
  logic [PW-1:0]        rr_ptr_r, rr_ptr_s;
  logic [NW-1:0]        tag_r [NUM_CORES];
  logic [NW-1:0]        tag_s [NUM_CORES];
  logic [31:0]          res_r [NUM_CORES];
  logic [31:0]          res_s [NUM_CORES];

  logic                 done_s;
  logic [NUM_CORES-1:0] core_start_s;
  logic [31:0]          core_nonce_s;
  logic                 mem_we_s;
  logic [15:0]          mem_addr_s;
  logic [31:0]          mem_write_data_s;

  logic                 disp_found_s;
  logic [PW-1:0]        disp_idx_s;
  logic                 grant_found_s;
  logic [PW-1:0]        grant_idx_s;

  // Next-state, dispatch / capture / writeback decisions and next output values
  always_comb begin
    state_s          = state_r;
    busy_s           = busy_r;
    pending_s        = pending_r;
    next_nonce_s     = next_nonce_r;
    rr_ptr_s         = rr_ptr_r;
    tag_s            = tag_r;
    res_s            = res_r;
    done_s           = 1'b0;
    core_start_s     = '0;
    core_nonce_s     = core_nonce;
    mem_we_s         = 1'b0;
    mem_addr_s       = mem_addr;
    mem_write_data_s = mem_write_data;
    disp_found_s     = 1'b0;
    disp_idx_s       = '0;
    grant_found_s    = 1'b0;
    grant_idx_s      = '0;

    // Lowest-index core that is neither running nor holding an unwritten result
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!disp_found_s && !busy_r[i] && !pending_r[i]) begin
        disp_found_s = 1'b1;
        disp_idx_s   = PW'(i);
      end else begin
        disp_found_s = disp_found_s;
      end
    end

    // First pending core at or after the round-robin pointer, circularly
    for (int k = 0; k < NUM_CORES; k++) begin
      if (!grant_found_s && pending_r[PW'((int'(rr_ptr_r) + k) % NUM_CORES)]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = PW'((int'(rr_ptr_r) + k) % NUM_CORES);
      end else begin
        grant_found_s = grant_found_s;
      end
    end

    case (state_r)
      IDLE: begin
        if (start) begin
          state_s      = RUN;
          next_nonce_s = '0;
          rr_ptr_s     = '0;
        end else begin
          state_s = IDLE;
        end
      end

      RUN: begin
        // Dispatch: a freed core only becomes eligible once its flags are clear
        if ((next_nonce_r < NW'(NUM_NONCES)) && disp_found_s) begin
          core_start_s[disp_idx_s] = 1'b1;
          core_nonce_s             = 32'(next_nonce_r);
          busy_s[disp_idx_s]       = 1'b1;
          tag_s[disp_idx_s]        = next_nonce_r;
          next_nonce_s             = next_nonce_r + NW'(1);
        end else begin
          next_nonce_s = next_nonce_r;
        end

        // Capture: completions from cores we did not launch are dropped
        for (int i = 0; i < NUM_CORES; i++) begin
          if (core_done[i] && busy_r[i]) begin
            res_s[i]     = core_hash[32*i +: 32];
            pending_s[i] = 1'b1;
            busy_s[i]    = 1'b0;
          end else begin
            pending_s[i] = pending_s[i];
          end
        end

        // Writeback uses the registered pending set, so capture-to-write is at least one cycle
        if (grant_found_s) begin
          mem_we_s               = 1'b1;
          mem_addr_s             = output_addr + 16'(tag_r[grant_idx_s]);
          mem_write_data_s       = res_r[grant_idx_s];
          pending_s[grant_idx_s] = 1'b0;
          rr_ptr_s               = PW'((int'(grant_idx_s) + 1) % NUM_CORES);
        end else begin
          mem_we_s = 1'b0;
        end

        // The sweep ends once every nonce is issued and nothing is left in flight
        if ((next_nonce_r == NW'(NUM_NONCES)) && (busy_r == '0) &&
            (pending_r == '0) && !grant_found_s) begin
          state_s = FINISH;
          done_s  = 1'b1;
        end else begin
          state_s = RUN;
        end
      end

      FINISH: begin
        state_s = IDLE;
      end

      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, per-core bookkeeping and registered outputs, with synchronous reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r        <= IDLE;
      busy_r         <= '0;
      pending_r      <= '0;
      next_nonce_r   <= '0;
      rr_ptr_r       <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        tag_r[i] <= '0;
        res_r[i] <= '0;
      end
      done           <= 1'b0;
      core_start     <= '0;
      core_nonce     <= '0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
    end else begin
      state_r        <= state_s;
      busy_r         <= busy_s;
      pending_r      <= pending_s;
      next_nonce_r   <= next_nonce_s;
      rr_ptr_r       <= rr_ptr_s;
      tag_r          <= tag_s;
      res_r          <= res_s;
      done           <= done_s;
      core_start     <= core_start_s;
      core_nonce     <= core_nonce_s;
      mem_we         <= mem_we_s;
      mem_addr       <= mem_addr_s;
      mem_write_data <= mem_write_data_s;
    end
  end

endmodule

// File: tb/tb_sha256_nonce_scheduler.sv
// Testbench for sha256_nonce_scheduler.
// A behavioural core array answers each launch after a chosen latency with
// hash = nonce ^ A5A5A5A5. A scoreboard checks the following for every sweep:
// each nonce is started once, each nonce is written once with the right data
// at base + nonce, and there is a single done pulse after the last write.
module tb_sha256_nonce_scheduler;

  localparam int NC = 4;
  localparam int NN = 16;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            start;
  logic [15:0]     output_addr;
  logic            done;
  logic [NC-1:0]   core_start;
  logic [31:0]     core_nonce;
  logic [NC-1:0]   core_done;
  logic [32*NC-1:0] core_hash;
  logic            mem_we;
  logic [15:0]     mem_addr;
  logic [31:0]     mem_write_data;

  always #5 clk = ~clk;

  sha256_nonce_scheduler #(.NUM_CORES(NC), .NUM_NONCES(NN)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .output_addr(output_addr),
    .done(done), .core_start(core_start), .core_nonce(core_nonce),
    .core_done(core_done), .core_hash(core_hash), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data)
  );

  int total = 0;
  int bad   = 0;

  // behavioural core array: 0 = replies only when fired by hand, 1 = 10 cycles, 2 = random 1..40
  int  lat_mode;
  bit  active [NC];
  int  cnonce [NC];
  int  cdn    [NC];

  // per-sweep scoreboard
  logic [15:0] base;
  int          started [NN];
  int          written [NN];
  logic [15:0] wr_addr [NN];
  int          wr_q [$];
  int          done_cnt;
  int          cyc;
  int          last_wr_cyc;
  int          done_cyc;

  typedef struct {
    logic [15:0] base;
    int          mode;
    bit          disturb;
    logic [15:0] lo_exp;
    logic [15:0] hi_exp;
  } vec_t;

  vec_t tbl [5];

  function automatic logic [31:0] hash_of(int n);
    return 32'(n) ^ 32'hA5A5A5A5;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_sb();
    for (int n = 0; n < NN; n++) begin
      started[n] = 0;
      written[n] = 0;
      wr_addr[n] = 16'h0;
    end
    wr_q.delete();
    done_cnt    = 0;
    last_wr_cyc = -1;
    done_cyc    = -1;
  endtask

  // one clock: sample outputs after the edge, update model, drive next inputs
  task automatic step();
    logic [15:0] d;
    int n;
    @(posedge clk);
    #1;
    cyc++;
    if (core_start != '0) begin
      check("start_onehot", 64'($countones(core_start)), 64'd1);
      for (int i = 0; i < NC; i++) begin
        if (core_start[i]) begin
          check("start_on_free_core", 64'(active[i]), 64'd0);
          check("nonce_range", 64'(core_nonce < 32'(NN)), 64'd1);
          if (core_nonce < 32'(NN)) started[core_nonce]++;
          active[i] = 1'b1;
          cnonce[i] = int'(core_nonce);
          cdn[i]    = (lat_mode == 0) ? -1 :
                      (lat_mode == 1) ? 10 : int'($urandom_range(40, 1));
        end
      end
    end
    if (mem_we) begin
      d = mem_addr - base;
      n = int'(d);
      check("wr_addr_range", 64'(n < NN), 64'd1);
      if (n < NN) begin
        check("wr_data", 64'(mem_write_data), 64'(hash_of(n)));
        written[n]++;
        wr_addr[n] = mem_addr;
        wr_q.push_back(n);
        last_wr_cyc = cyc;
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    core_done = '0;
    for (int i = 0; i < NC; i++) core_hash[32*i +: 32] = $urandom();
    for (int i = 0; i < NC; i++) begin
      if (active[i] && cdn[i] > 0) begin
        cdn[i]--;
        if (cdn[i] == 0) begin
          core_done[i]          = 1'b1;
          core_hash[32*i +: 32] = hash_of(cnonce[i]);
          active[i]             = 1'b0;
        end
      end
    end
  endtask

  // hand-fired completion pulse on the cores in mask (garbage hash on cores never launched)
  task automatic fire(logic [NC-1:0] mask);
    for (int i = 0; i < NC; i++) begin
      if (mask[i]) begin
        core_done[i]          = 1'b1;
        core_hash[32*i +: 32] = active[i] ? hash_of(cnonce[i]) : 32'hDEADBEEF;
        active[i]             = 1'b0;
      end
    end
  endtask

  task automatic finish_and_check(string tag, logic [15:0] lo_exp, logic [15:0] hi_exp);
    for (int k = 0; k < 3000 && done_cnt == 0; k++) step();
    check({tag, "_done_seen"}, 64'(done_cnt), 64'd1);
    for (int k = 0; k < 6; k++) step();
    check({tag, "_single_done"}, 64'(done_cnt), 64'd1);
    check({tag, "_write_count"}, 64'(wr_q.size()), 64'(NN));
    check({tag, "_done_after_last_write"}, 64'(done_cyc > last_wr_cyc), 64'd1);
    for (int n = 0; n < NN; n++) begin
      check({tag, "_started_once"}, 64'(started[n]), 64'd1);
      check({tag, "_written_once"}, 64'(written[n]), 64'd1);
    end
    check({tag, "_addr_first_nonce"}, 64'(wr_addr[0]), 64'(lo_exp));
    check({tag, "_addr_last_nonce"}, 64'(wr_addr[NN-1]), 64'(hi_exp));
  endtask

  task automatic run_sweep(string tag, vec_t v);
    clear_sb();
    base        = v.base;
    output_addr = v.base;
    lat_mode    = v.mode;
    start = 1'b1;
    step();
    start = 1'b0;
    if (v.disturb) begin
      step();
      start = 1'b1;
      fire(4'b1000);
      step();
      start = 1'b0;
    end
    finish_and_check(tag, v.lo_exp, v.hi_exp);
  endtask

  initial begin
    logic [NC-1:0] act_mask;
    int            snap [NC];
    int            exp_seq [4];

    tbl[0] = '{16'h0100, 1, 1'b0, 16'h0100, 16'h010F};
    tbl[1] = '{16'h0100, 2, 1'b0, 16'h0100, 16'h010F};
    tbl[2] = '{16'hFFF8, 1, 1'b0, 16'hFFF8, 16'h0007};
    tbl[3] = '{16'h0100, 2, 1'b1, 16'h0100, 16'h010F};
    tbl[4] = '{16'h2000, 2, 1'b0, 16'h2000, 16'h200F};

    for (int i = 0; i < NC; i++) begin
      active[i] = 1'b0;
      cnonce[i] = 0;
      cdn[i]    = -1;
    end
    cyc = 0;
    lat_mode = 1;
    base = 16'h0;
    clear_sb();
    reset_n = 1'b0;
    start = 1'b0;
    output_addr = 16'h0;
    core_done = '0;
    core_hash = '0;

    // reset state
    step();
    step();
    check("rst_ctrl", 64'({done, core_start, mem_we}), 64'd0);
    check("rst_data", 64'({core_nonce, mem_write_data}), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    reset_n = 1'b1;
    step();
    step();
    check("idle_quiet", 64'({done, core_start, mem_we}), 64'd0);

    // full sweeps from the table
    for (int r = 0; r < 5; r++) run_sweep($sformatf("sweep%0d", r), tbl[r]);

    // simultaneous completion with the round-robin pointer at 2
    clear_sb();
    base = 16'h0100;
    output_addr = 16'h0100;
    lat_mode = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("rr_all_launched", 64'(active[0] && active[1] && active[2] && active[3]), 64'd1);
    fire(4'b0010);
    step();
    check("rr_no_write_on_capture", 64'(mem_we), 64'd0);
    step();
    check("rr_single_we", 64'(mem_we), 64'd1);
    check("rr_single_addr", 64'(mem_addr), 64'(16'h0100 + 16'(snap_nonce(1))));
    step();
    step();
    step();
    for (int i = 0; i < NC; i++) snap[i] = cnonce[i];
    exp_seq[0] = snap[2];
    exp_seq[1] = snap[3];
    exp_seq[2] = snap[0];
    exp_seq[3] = snap[1];
    fire(4'b1111);
    lat_mode = 1;
    step();
    check("rr_capture_latency", 64'(mem_we), 64'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("rr_burst_we", 64'(mem_we), 64'd1);
      check("rr_burst_order", 64'(mem_addr), 64'(16'h0100 + 16'(exp_seq[k])));
    end
    finish_and_check("rr", 16'h0100, 16'h010F);

    // reset in the middle of a sweep
    clear_sb();
    base = 16'h0100;
    output_addr = 16'h0100;
    lat_mode = 1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 15; k++) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("midrst_ctrl", 64'({done, core_start, mem_we}), 64'd0);
    check("midrst_data", 64'({core_nonce, mem_write_data}), 64'd0);
    check("midrst_addr", 64'(mem_addr), 64'd0);
    act_mask = '0;
    for (int i = 0; i < NC; i++) act_mask[i] = active[i];
    fire(act_mask);
    for (int k = 0; k < 6; k++) begin
      step();
      check("late_done_ignored", 64'({done, core_start, mem_we}), 64'd0);
    end
    run_sweep("after_rst", tbl[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  function automatic int snap_nonce(int i);
    return cnonce[i];
  endfunction

endmodule
